// File: rtl/schieber_arbiter_if.sv
// Bundle between two rotate requesters plus one result consumer and the
// shared rotator arbiter. The master side drives the requests and the
// consumer acceptance. The slave side (the arbiter) drives the grants and
// the result.
interface schieber_arbiter_if #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
);
    logic                  A_Anfrage;
    logic [BREITE-1:0]     A_Zahl;
    logic [LOG2BREITE-1:0] A_Stellen;
    logic                  A_SchiebRechts;
    logic                  A_Bereit;

    logic                  B_Anfrage;
    logic [BREITE-1:0]     B_Zahl;
    logic [LOG2BREITE-1:0] B_Stellen;
    logic                  B_SchiebRechts;
    logic                  B_Bereit;

    logic [BREITE-1:0]     Ergebnis;
    logic                  ErgebnisGueltig;
    logic                  ErgebnisQuelle;
    logic                  ErgebnisAnnahme;

    modport master (
        output A_Anfrage, A_Zahl, A_Stellen, A_SchiebRechts,
        output B_Anfrage, B_Zahl, B_Stellen, B_SchiebRechts,
        output ErgebnisAnnahme,
        input  A_Bereit, B_Bereit,
        input  Ergebnis, ErgebnisGueltig, ErgebnisQuelle
    );

    modport slave (
        input  A_Anfrage, A_Zahl, A_Stellen, A_SchiebRechts,
        input  B_Anfrage, B_Zahl, B_Stellen, B_SchiebRechts,
        input  ErgebnisAnnahme,
        output A_Bereit, B_Bereit,
        output Ergebnis, ErgebnisGueltig, ErgebnisQuelle
    );
endinterface

// File: rtl/schieber_arbiter.sv
// Round-robin arbiter that shares one cyclic barrel rotator between two
// requesters. The result sits in a single-entry output register. That
// register is refilled in the same cycle it is consumed, so throughput is
// one result per clock.
module schieber_arbiter #(
    parameter int BREITE     = 32,
    parameter int LOG2BREITE = 5
) (
    input  logic               Takt,
    input  logic               Reset_n,
    schieber_arbiter_if.slave  bus
);

    logic [BREITE-1:0]     ergebnis_q, ergebnis_d;
    logic                  gueltig_q, gueltig_d;
    logic                  quelle_q, quelle_d;
    logic                  vorrang_q, vorrang_d;   // 0 = A has priority, 1 = B

    logic                  frei;
    logic                  a_bereit, b_bereit;
    logic                  a_xfer, b_xfer;
    logic [BREITE-1:0]     operand;
    logic [LOG2BREITE-1:0] stellen;
    logic                  rechts;
    logic [LOG2BREITE-1:0] rechts_betrag;
    logic [BREITE-1:0]     rotiert;

    // The output slot can take a new result when it is empty or is drained
    // this cycle. Grants use only the other port's request, never the port's
    // own request, so no combinational loop can form through a requester.
    // Grants are suppressed while reset is asserted.
    assign frei     = !gueltig_q || bus.ErgebnisAnnahme;
    assign a_bereit = Reset_n && frei && (!vorrang_q || !bus.B_Anfrage);
    assign b_bereit = Reset_n && frei && ( vorrang_q || !bus.A_Anfrage);
    assign a_xfer   = bus.A_Anfrage && a_bereit;
    assign b_xfer   = bus.B_Anfrage && b_bereit;

    assign bus.A_Bereit        = a_bereit;
    assign bus.B_Bereit        = b_bereit;
    assign bus.Ergebnis        = ergebnis_q;
    assign bus.ErgebnisGueltig = gueltig_q;
    assign bus.ErgebnisQuelle  = quelle_q;

    // Operand select feeding the single shared rotator. A left rotate by s is
    // a right rotate by (BREITE - s) mod BREITE, i.e. the two's complement of s.
    always_comb begin
        operand = b_xfer ? bus.B_Zahl         : bus.A_Zahl;
        stellen = b_xfer ? bus.B_Stellen      : bus.A_Stellen;
        rechts  = b_xfer ? bus.B_SchiebRechts : bus.A_SchiebRechts;
        rechts_betrag = rechts ? stellen : (~stellen + 1'b1);
    end

    // Logarithmic barrel rotator (right): stage i rotates by 2**i when bit i is set.
    always_comb begin
        rotiert = operand;
        for (int i = 0; i < LOG2BREITE; i++) begin
            if (rechts_betrag[i]) begin
                rotiert = (rotiert >> (1 << i)) | (rotiert << (BREITE - (1 << i)));
            end
        end
    end

    // Next-state logic. A transfer loads the output slot and hands priority
    // to the port not served. A bare consume empties the slot.
    always_comb begin
        ergebnis_d = ergebnis_q;
        gueltig_d  = gueltig_q;
        quelle_d   = quelle_q;
        vorrang_d  = vorrang_q;
        if (a_xfer || b_xfer) begin
            ergebnis_d = rotiert;
            gueltig_d  = 1'b1;
            quelle_d   = b_xfer;
            vorrang_d  = a_xfer;
        end else if (gueltig_q && bus.ErgebnisAnnahme) begin
            gueltig_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Takt) begin
        if (!Reset_n) begin
            ergebnis_q <= '0;
            gueltig_q  <= 1'b0;
            quelle_q   <= 1'b0;
            vorrang_q  <= 1'b0;
        end else begin
            ergebnis_q <= ergebnis_d;
            gueltig_q  <= gueltig_d;
            quelle_q   <= quelle_d;
            vorrang_q  <= vorrang_d;
        end
    end

endmodule

// File: tb/tb_schieber_arbiter.sv
// Directed testbench for schieber_arbiter: reset, single requesters, rotation
// corner cases, round-robin, back-pressure, reset discard and back-to-back.
module tb_schieber_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    schieber_arbiter_if #(.BREITE(32), .LOG2BREITE(5)) bus ();

    schieber_arbiter #(.BREITE(32), .LOG2BREITE(5)) dut (
        .Takt    (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] BB_ZAHL [4] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h0000_F000};
    localparam logic [4:0]  BB_ST   [4] = '{5'd0, 5'd1, 5'd1, 5'd12};
    localparam logic        BB_RE   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] BB_EXP  [4] = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0001, 32'h0000_000F};

    task automatic set_a(input logic anf, input logic [31:0] z, input logic [4:0] s, input logic r);
        bus.A_Anfrage = anf; bus.A_Zahl = z; bus.A_Stellen = s; bus.A_SchiebRechts = r;
    endtask

    task automatic set_b(input logic anf, input logic [31:0] z, input logic [4:0] s, input logic r);
        bus.B_Anfrage = anf; bus.B_Zahl = z; bus.B_Stellen = s; bus.B_SchiebRechts = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_a(1'b1, 32'h1234_5678, 5'd3, 1'b0);
        set_b(1'b1, 32'h8765_4321, 5'd3, 1'b1);
        bus.ErgebnisAnnahme = 1'b1;
        #2;
        checks++;
        if (bus.A_Bereit !== 1'b0 || bus.B_Bereit !== 1'b0) begin
            errors++;
            $display("FAIL reset_bereit: got A=%b B=%b expected A=0 B=0", bus.A_Bereit, bus.B_Bereit);
        end
        tick();
        checks++;
        if (bus.ErgebnisGueltig !== 1'b0 || bus.Ergebnis !== 32'h0 || bus.ErgebnisQuelle !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got gueltig=%b erg=%h quelle=%b expected 0 00000000 0",
                     bus.ErgebnisGueltig, bus.Ergebnis, bus.ErgebnisQuelle);
        end
        rst_n = 1'b1;
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        $display("reset: gueltig=%b erg=%h", bus.ErgebnisGueltig, bus.Ergebnis);
    endtask

    task automatic test_a_only();
        bus.ErgebnisAnnahme = 1'b1;
        set_a(1'b1, 32'h8000_0001, 5'd1, 1'b0);
        #2;
        checks++;
        if (bus.A_Bereit !== 1'b1) begin
            errors++;
            $display("FAIL a_only_grant: got %b expected 1", bus.A_Bereit);
        end
        tick();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if (bus.Ergebnis !== 32'h0000_0003 || bus.ErgebnisGueltig !== 1'b1 || bus.ErgebnisQuelle !== 1'b0) begin
            errors++;
            $display("FAIL a_only_result: got erg=%h g=%b q=%b expected 00000003 1 0",
                     bus.Ergebnis, bus.ErgebnisGueltig, bus.ErgebnisQuelle);
        end
        $display("a_only: erg=%h q=%b", bus.Ergebnis, bus.ErgebnisQuelle);
    endtask

    task automatic test_b_only();
        logic [31:0] zin [4]  = '{32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678};
        logic [4:0]  sin [4]  = '{5'd4, 5'd0, 5'd0, 5'd8};
        logic        rin [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] zexp [4] = '{32'h1000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h7812_3456};
        bus.ErgebnisAnnahme = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_b(1'b1, zin[i], sin[i], rin[i]);
            #2;
            checks++;
            if (bus.B_Bereit !== 1'b1) begin
                errors++;
                $display("FAIL b_only_grant[%0d]: got %b expected 1", i, bus.B_Bereit);
            end
            tick();
            checks++;
            if (bus.Ergebnis !== zexp[i] || bus.ErgebnisQuelle !== 1'b1 || bus.ErgebnisGueltig !== 1'b1) begin
                errors++;
                $display("FAIL b_only_result[%0d]: got erg=%h q=%b g=%b expected %h 1 1",
                         i, bus.Ergebnis, bus.ErgebnisQuelle, bus.ErgebnisGueltig, zexp[i]);
            end
            $display("b_only[%0d]: erg=%h q=%b", i, bus.Ergebnis, bus.ErgebnisQuelle);
        end
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        // extra left rotate through port A
        set_a(1'b1, 32'h1234_5678, 5'd8, 1'b0);
        tick();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if (bus.Ergebnis !== 32'h3456_7812 || bus.ErgebnisQuelle !== 1'b0) begin
            errors++;
            $display("FAIL a_left8: got erg=%h q=%b expected 34567812 0", bus.Ergebnis, bus.ErgebnisQuelle);
        end
        $display("a_left8: erg=%h", bus.Ergebnis);
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.ErgebnisAnnahme = 1'b1;
        set_a(1'b1, 32'h0000_00A0, 5'd0, 1'b0);
        set_b(1'b1, 32'h0000_000B, 5'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (bus.A_Bereit !== (i % 2 == 0) || bus.B_Bereit !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got A=%b B=%b expected A=%b B=%b",
                         i, bus.A_Bereit, bus.B_Bereit, (i % 2 == 0), (i % 2 == 1));
            end
            tick();
            checks++;
            if (bus.ErgebnisQuelle !== (i % 2 == 1) || bus.ErgebnisGueltig !== 1'b1 ||
                bus.Ergebnis !== ((i % 2 == 0) ? 32'h0000_00A0 : 32'h0000_000B)) begin
                errors++;
                $display("FAIL rr_result[%0d]: got q=%b g=%b erg=%h", i,
                         bus.ErgebnisQuelle, bus.ErgebnisGueltig, bus.Ergebnis);
            end
            $display("rr[%0d]: q=%b erg=%h", i, bus.ErgebnisQuelle, bus.Ergebnis);
        end
        bus.ErgebnisAnnahme = 1'b0;
    endtask

    task automatic test_backpressure();
        // result 0xA0 from A pending; priority now belongs to B
        bus.ErgebnisAnnahme = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (bus.A_Bereit !== 1'b0 || bus.B_Bereit !== 1'b0) begin
                errors++;
                $display("FAIL bp_bereit[%0d]: got A=%b B=%b expected 0 0", i, bus.A_Bereit, bus.B_Bereit);
            end
            tick();
            checks++;
            if (bus.Ergebnis !== 32'h0000_00A0 || bus.ErgebnisQuelle !== 1'b0 || bus.ErgebnisGueltig !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got erg=%h q=%b g=%b expected 000000a0 0 1",
                         i, bus.Ergebnis, bus.ErgebnisQuelle, bus.ErgebnisGueltig);
            end
            $display("bp_hold[%0d]: erg=%h", i, bus.Ergebnis);
        end
        bus.ErgebnisAnnahme = 1'b1;
        #2;
        checks++;
        if (bus.A_Bereit !== 1'b0 || bus.B_Bereit !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_grant: got A=%b B=%b expected A=0 B=1", bus.A_Bereit, bus.B_Bereit);
        end
        tick();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if (bus.Ergebnis !== 32'h0000_000B || bus.ErgebnisQuelle !== 1'b1 || bus.ErgebnisGueltig !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_result: got erg=%h q=%b g=%b expected 0000000b 1 1",
                     bus.Ergebnis, bus.ErgebnisQuelle, bus.ErgebnisGueltig);
        end
        tick();
        checks++;
        if (bus.ErgebnisGueltig !== 1'b0) begin
            errors++;
            $display("FAIL consume_drop: got g=%b expected 0", bus.ErgebnisGueltig);
        end
        // acceptance toggling while empty changes nothing
        bus.ErgebnisAnnahme = 1'b0;
        tick();
        bus.ErgebnisAnnahme = 1'b1;
        tick();
        checks++;
        if (bus.ErgebnisGueltig !== 1'b0 || bus.ErgebnisQuelle !== 1'b1) begin
            errors++;
            $display("FAIL idle_annahme: got g=%b q=%b expected 0 1", bus.ErgebnisGueltig, bus.ErgebnisQuelle);
        end
        $display("bp_release: erg=%h g=%b", bus.Ergebnis, bus.ErgebnisGueltig);
    endtask

    task automatic test_reset_discard();
        // serve A so priority moves to B, leave the result unconsumed
        bus.ErgebnisAnnahme = 1'b1;
        set_a(1'b1, 32'h0000_0055, 5'd0, 1'b0);
        tick();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        bus.ErgebnisAnnahme = 1'b0;
        checks++;
        if (bus.ErgebnisGueltig !== 1'b1 || bus.Ergebnis !== 32'h0000_0055) begin
            errors++;
            $display("FAIL discard_setup: got g=%b erg=%h expected 1 00000055", bus.ErgebnisGueltig, bus.Ergebnis);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.ErgebnisGueltig !== 1'b0 || bus.Ergebnis !== 32'h0 || bus.ErgebnisQuelle !== 1'b0) begin
            errors++;
            $display("FAIL discard_state: got g=%b erg=%h q=%b expected 0 00000000 0",
                     bus.ErgebnisGueltig, bus.Ergebnis, bus.ErgebnisQuelle);
        end
        set_a(1'b1, 32'h0000_0066, 5'd0, 1'b0);
        set_b(1'b1, 32'h0000_0077, 5'd0, 1'b0);
        #2;
        checks++;
        if (bus.A_Bereit !== 1'b1 || bus.B_Bereit !== 1'b0) begin
            errors++;
            $display("FAIL discard_vorrang: got A=%b B=%b expected A=1 B=0", bus.A_Bereit, bus.B_Bereit);
        end
        tick();
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        checks++;
        if (bus.Ergebnis !== 32'h0000_0066 || bus.ErgebnisQuelle !== 1'b0) begin
            errors++;
            $display("FAIL discard_next: got erg=%h q=%b expected 00000066 0", bus.Ergebnis, bus.ErgebnisQuelle);
        end
        $display("reset_discard: erg=%h q=%b", bus.Ergebnis, bus.ErgebnisQuelle);
    endtask

    task automatic test_back_to_back();
        bus.ErgebnisAnnahme = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, BB_ZAHL[i], BB_ST[i], BB_RE[i]);
            #2;
            checks++;
            if (bus.A_Bereit !== 1'b1) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: got %b expected 1", i, bus.A_Bereit);
            end
            tick();
            checks++;
            if (bus.Ergebnis !== BB_EXP[i] || bus.ErgebnisGueltig !== 1'b1 || bus.ErgebnisQuelle !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result[%0d]: got erg=%h g=%b q=%b expected %h 1 0",
                         i, bus.Ergebnis, bus.ErgebnisGueltig, bus.ErgebnisQuelle, BB_EXP[i]);
            end
            $display("b2b[%0d]: erg=%h g=%b", i, bus.Ergebnis, bus.ErgebnisGueltig);
        end
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        set_a(1'b0, 32'h0, 5'd0, 1'b0);
        set_b(1'b0, 32'h0, 5'd0, 1'b0);
        bus.ErgebnisAnnahme = 1'b0;
        test_reset();
        test_a_only();
        test_b_only();
        test_round_robin();
        test_backpressure();
        test_reset_discard();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/schieber_arbiter.md
SCHIEBER_ARBITER -- requirements
Module: schieber_arbiter

Interface
REQ-001 Parameter: BREITE, 32, data width in bits.
REQ-002 Parameter: LOG2BREITE, 5, rotate-amount width; SHALL equal log2(BREITE).
REQ-003 Takt  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  synchronous, active-low reset, sampled on rising edge of Takt.
REQ-005 A_Anfrage  input  1  requester A holds a valid rotate request.
REQ-006 A_Zahl  input  BREITE  requester A operand.
REQ-007 A_Stellen  input  LOG2BREITE  requester A rotate amount.
REQ-008 A_SchiebRechts  input  1  requester A direction: 1 = rotate right, 0 = rotate left.
REQ-009 A_Bereit  output  1  request A accepted this cycle if A_Anfrage is high.
REQ-010 B_Anfrage, B_Zahl, B_Stellen, B_SchiebRechts, B_Bereit SHALL mirror REQ-005..REQ-009 for requester B.
REQ-011 Ergebnis  output  BREITE  registered rotate result.
REQ-012 ErgebnisGueltig  output  1  Ergebnis holds an unconsumed result.
REQ-013 ErgebnisQuelle  output  1  originator of Ergebnis: 0 = A, 1 = B.
REQ-014 ErgebnisAnnahme  input  1  consumer takes Ergebnis this cycle when ErgebnisGueltig is high.

Function
REQ-015 Block SHALL own exactly one combinational cyclic rotator shared between A and B; rotation is cyclic, no bits lost.
REQ-016 Output stage "frei" = !ErgebnisGueltig || ErgebnisAnnahme; grants only when frei.
REQ-017 Transfer on a port = Anfrage && Bereit in the same cycle; at most one transfer per cycle.
REQ-018 Bereit SHALL be combinational: X_Bereit = frei && (Vorrang==X || !Y_Anfrage), with Y the other port.
REQ-019 Bereit SHALL NOT depend on the requesting port's own Anfrage, avoiding combinational loops.
REQ-020 Round-robin: Vorrang register (0 = A, 1 = B); on every transfer, Vorrang SHALL switch to the port not served.
REQ-021 Single requester with frei high SHALL be granted regardless of Vorrang; Vorrang still switches.
REQ-022 Latency: result of a transfer in cycle n appears on Ergebnis with ErgebnisGueltig=1 in cycle n+1.
REQ-023 Throughput: with ErgebnisAnnahme held high, one transfer per cycle sustained (back-to-back).
REQ-024 While ErgebnisGueltig && !ErgebnisAnnahme, Ergebnis and ErgebnisQuelle SHALL stay stable and both Bereit low.
REQ-025 Consume without new transfer: ErgebnisGueltig SHALL drop to 0 next cycle; Ergebnis may retain its old value.
REQ-026 Consume plus transfer in the same cycle: new result replaces old next cycle, ErgebnisGueltig stays 1.
REQ-027 Stellen = 0 SHALL pass Zahl unchanged in both directions.
REQ-028 Requester SHALL hold Zahl/Stellen/SchiebRechts stable while Anfrage is high and Bereit is low; block samples only on transfer.
REQ-029 Behaviour of ErgebnisAnnahme while ErgebnisGueltig is low SHALL be ignored (no state change).

Reset
REQ-030 Reset_n low at a rising edge: ErgebnisGueltig=0, Ergebnis=0, ErgebnisQuelle=0, Vorrang=0 (A).
REQ-031 Pending unconsumed result SHALL be discarded by reset; no transfer accepted in a cycle where Reset_n is low (A_Bereit=B_Bereit=0).
REQ-032 First cycle after reset release SHALL behave as frei with Vorrang=A.

Verification
REQ-033 A only, A_Zahl=0x80000001, A_Stellen=1, left, Annahme=1 -> next cycle Ergebnis=0x00000003, Gueltig=1, Quelle=0.
REQ-034 B only, B_Zahl=0x00000001, B_Stellen=4, right -> next cycle Ergebnis=0x10000000, Quelle=1; then Stellen=0 with 0xDEADBEEF -> 0xDEADBEEF.
REQ-035 After reset, A and B request simultaneously for 3 cycles, Annahme=1 -> grants A,B,A; Quelle sequence 0,1,0 one cycle later.
REQ-036 Result valid, Annahme low 3 cycles with both requesting -> Ergebnis/Quelle stable, both Bereit low; Annahme high -> grant same cycle, new result next.
REQ-037 Result valid and unconsumed, Reset_n low 1 cycle -> Gueltig=0, Ergebnis=0, Vorrang=A; pending result never delivered.
REQ-038 Single-requester back-to-back: A requests 4 cycles, B idle -> 4 results, Gueltig continuously high, Quelle=0 each.
